// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel, runtime-programmable integer clock divider.
// Each channel divides clk_in by its own ratio N (clamped to >= 2), producing
// a registered near-50% duty waveform (high for ceil(N/2) cycles) and a
// one-cycle tick at the start of each period. New ratios are staged in a
// pending register and swapped in only at a period boundary, acknowledged by
// a one-cycle ratio_ack pulse coincident with that boundary's tick.
module clk_div_prog #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                    clk_in,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH*DIV_W-1:0] ratio,
    input  logic [NUM_CH-1:0]       load,
    input  logic                    sync_restart,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       ratio_ack
);

    // Ratios below 2 cannot form a high and a low phase, so they saturate to 2.
    function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] r);
        logic [DIV_W-1:0] two;
        two = DIV_W'(2);
        return (r < two) ? two : r;
    endfunction

    // High time of a period of length n: ceil(n/2), one bit wider to hold n+1.
    function automatic logic [DIV_W:0] high_time(input logic [DIV_W-1:0] n);
        logic [DIV_W:0] sum;
        sum = {1'b0, n} + (DIV_W+1)'(1);
        return sum >> 1;
    endfunction

    localparam logic [DIV_W-1:0] DEF_R    = (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DEF_LAST = DEF_R - DIV_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] act;
        logic [DIV_W-1:0] pend;
        logic             pvld;
        logic             co;
        logic             tk;
        logic             ak;

        logic [DIV_W-1:0] new_r;
        logic [DIV_W-1:0] last;
        logic [DIV_W-1:0] cnt_inc;
        logic             at_end;
        logic             boundary;
        logic             co_next;

        assign new_r    = clamp_ratio(ratio[i*DIV_W +: DIV_W]);
        assign last     = act - DIV_W'(1);
        assign cnt_inc  = cnt + DIV_W'(1);
        // >= rather than == keeps the count bounded even if state were ever upset
        assign at_end   = (cnt >= last);
        assign boundary = sync_restart | (enable[i] & at_end);
        assign co_next  = ({1'b0, cnt_inc} < high_time(act));

        // Per-channel count, ratio staging and registered waveform/tick/ack.
        // Reset parks the count at the last phase so the first enabled edge
        // begins a fresh period.
        always_ff @(posedge clk_in or negedge reset_n) begin
            if (!reset_n) begin
                cnt  <= DEF_LAST;
                act  <= DEF_R;
                pend <= DEF_R;
                pvld <= 1'b0;
                co   <= 1'b0;
                tk   <= 1'b0;
                ak   <= 1'b0;
            end else begin
                tk <= 1'b0;
                ak <= 1'b0;
                if (boundary) begin
                    cnt <= '0;
                    co  <= 1'b1;
                    tk  <= 1'b1;
                    if (pvld) begin
                        act  <= pend;
                        pvld <= 1'b0;
                        ak   <= 1'b1;
                    end
                end else if (enable[i]) begin
                    cnt <= cnt_inc;
                    co  <= co_next;
                end
                // A load on a boundary edge stages the value for the next boundary;
                // the swap above already consumed the previous pending value.
                if (load[i]) begin
                    pend <= new_r;
                    pvld <= 1'b1;
                end
            end
        end

        assign clk_out[i]   = co;
        assign tick[i]      = tk;
        assign ratio_ack[i] = ak;
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog: table-driven vectors, directed corner sequences
// and randomized stimulus, all checked against a behavioural period model.
module tb_clk_div_prog;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;
    localparam int DEFDIV = 2;

    logic                    clk_in = 1'b0;
    logic                    reset_n;
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH*DIV_W-1:0] ratio;
    logic [NUM_CH-1:0]       load;
    logic                    sync_restart;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       ratio_ack;

    clk_div_prog #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFDIV)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .enable(enable), .ratio(ratio),
        .load(load), .sync_restart(sync_restart), .clk_out(clk_out),
        .tick(tick), .ratio_ack(ratio_ack)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: position k within a period of length n.
    int m_k[NUM_CH], m_n[NUM_CH], m_pend[NUM_CH], m_pv[NUM_CH];
    logic [NUM_CH-1:0] m_co, m_tk, m_ak;

    typedef struct {
        logic [1:0] en;
        logic [1:0] ld;
        logic [7:0] r0;
        logic [7:0] r1;
        logic       rs;
        logic [1:0] co;
        logic [1:0] tk;
        logic [1:0] ak;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_n[c] = DEFDIV; m_k[c] = DEFDIV - 1; m_pend[c] = DEFDIV; m_pv[c] = 0;
        end
        m_co = '0; m_tk = '0; m_ak = '0;
    endtask

    task automatic model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            int r;
            m_tk[c] = 1'b0;
            m_ak[c] = 1'b0;
            if (sync_restart || enable[c]) begin
                if (sync_restart || m_k[c] == m_n[c] - 1) begin
                    m_k[c] = 0;
                    m_tk[c] = 1'b1;
                    if (m_pv[c] != 0) begin
                        m_n[c] = m_pend[c]; m_pv[c] = 0; m_ak[c] = 1'b1;
                    end
                end else begin
                    m_k[c] = m_k[c] + 1;
                end
                m_co[c] = (m_k[c] < (m_n[c] + 1) / 2);
            end
            if (load[c]) begin
                r = int'((ratio >> (c * DIV_W)) & 16'h00FF);
                m_pend[c] = (r < 2) ? 2 : r;
                m_pv[c] = 1;
            end
        end
    endtask

    // One clock: DUT and model consume the same inputs, outputs compared after the edge.
    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        chk("clk_out", 32'(clk_out), 32'(m_co));
        chk("tick", 32'(tick), 32'(m_tk));
        chk("ratio_ack", 32'(ratio_ack), 32'(m_ak));
    endtask

    task automatic drive(input logic [1:0] en, input logic [1:0] ld,
                         input logic [7:0] r0, input logic [7:0] r1, input logic rs);
        enable = en; load = ld; ratio = {r1, r0}; sync_restart = rs;
    endtask

    initial begin
        int cnt_both, first12, steps;
        logic [1:0] co_hold;

        // Vectors start from reset: ch0 only, ch1 stays disabled at its defaults.
        vt.push_back('{2'b00, 2'b01, 8'd4, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b01, 2'b01, 2'b01});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00});
        vt.push_back('{2'b01, 2'b01, 8'd6, 8'd0, 1'b0, 2'b01, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b01, 2'b01, 2'b01});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b01, 8'd7, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b01, 8'd3, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b01, 2'b01, 2'b01});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00});
        vt.push_back('{2'b01, 2'b01, 8'd1, 8'd0, 1'b0, 2'b01, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b01, 2'b01, 2'b01});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00});
        vt.push_back('{2'b01, 2'b00, 8'd0, 8'd0, 1'b0, 2'b01, 2'b01, 2'b00});
        vt.push_back('{2'b00, 2'b00, 8'd0, 8'd0, 1'b0, 2'b01, 2'b00, 2'b00});

        // Reset state
        reset_n = 1'b0;
        drive(2'b00, 2'b00, 8'd0, 8'd0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset_outputs", 32'({clk_out, tick, ratio_ack}), 32'd0);
        @(negedge clk_in);
        reset_n = 1'b1;

        // Table-driven vectors
        foreach (vt[i]) begin
            drive(vt[i].en, vt[i].ld, vt[i].r0, vt[i].r1, vt[i].rs);
            step();
            chk($sformatf("vec%0d", i), 32'({clk_out, tick, ratio_ack}),
                32'({vt[i].co, vt[i].tk, vt[i].ak}));
        end

        // Out-of-phase channels at 4 and 6, then sync_restart aligns them
        drive(2'b11, 2'b11, 8'd4, 8'd6, 1'b0);
        step();
        drive(2'b01, 2'b00, 8'd0, 8'd0, 1'b0);
        repeat (5) step();
        drive(2'b11, 2'b00, 8'd0, 8'd0, 1'b0);
        repeat (7) step();
        drive(2'b11, 2'b00, 8'd0, 8'd0, 1'b1);
        step();
        chk("restart_align", 32'({clk_out, tick}), 32'(4'b1111));
        drive(2'b11, 2'b00, 8'd0, 8'd0, 1'b0);
        cnt_both = 0; first12 = 0;
        for (int s = 1; s <= 12; s++) begin
            step();
            if (tick == 2'b11) begin
                cnt_both++;
                if (s == 12) first12 = 1;
            end
        end
        chk("common_tick_count", 32'(cnt_both), 32'd1);
        chk("common_tick_at_12", 32'(first12), 32'd1);

        // Enable held low for 3 cycles at k=2 stretches the ratio-4 period to 7
        drive(2'b11, 2'b00, 8'd0, 8'd0, 1'b1);
        step();
        steps = 0;
        for (int s = 1; s <= 20 && steps == 0; s++) begin
            drive((s >= 3 && s <= 5) ? 2'b10 : 2'b11, 2'b00, 8'd0, 8'd0, 1'b0);
            if (s == 3) co_hold = clk_out;
            step();
            if (s >= 3 && s <= 5)
                chk("freeze_hold", 32'({clk_out[0], tick[0]}), 32'({co_hold[0], 1'b0}));
            if (tick[0]) steps = s;
        end
        chk("stretched_period", 32'(steps), 32'd7);

        // Randomized traffic against the model
        for (int s = 0; s < 600; s++) begin
            logic [1:0] en, ld;
            en = 2'($urandom_range(0, 3) != 0 ? 2'b11 : 2'($urandom_range(0, 3)));
            ld = 2'(($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0);
            drive(en, ld, 8'($urandom_range(0, 9)), 8'($urandom_range(0, 9)),
                  ($urandom_range(0, 63) == 0));
            step();
        end

        // Asynchronous reset mid-period with a pending load
        drive(2'b11, 2'b11, 8'd9, 8'd9, 1'b0);
        step();
        drive(2'b11, 2'b00, 8'd0, 8'd0, 1'b0);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 32'({clk_out, tick, ratio_ack}), 32'd0);
        model_reset();
        @(posedge clk_in);
        #3;
        reset_n = 1'b1;
        cnt_both = 0;
        for (int s = 0; s < 10; s++) begin
            step();
            if (ratio_ack != 2'b00) cnt_both++;
        end
        chk("no_ack_after_reset", 32'(cnt_both), 32'd0);
        chk("default_ratio_toggle", 32'(clk_out), 32'(2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Multi-channel, runtime-programmable integer clock divider; successor to the fixed divide-by-two divider.
- Each of NUM_CH channels divides clk_in by its own ratio N and produces:
  - clk_out: a registered, near-50% duty clock-enable-style waveform.
  - tick: a one-cycle pulse at each period start.
- Ratio changes are glitch-free: a new ratio takes effect only at a period boundary and is acknowledged.
- Sits in the clocking/timebase area, feeding baud, PWM and sample-rate logic that runs on clk_in.

Parameters:
- NUM_CH, 2, number of independent divider channels (>=1).
- DIV_W, 8, width of each ratio field and internal counter (>=2).
- DEFAULT_DIV, 2, ratio loaded into every channel at reset (2 .. 2^DIV_W-1).

Ports:
- clk_in  input  1  single clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  NUM_CH  per-channel count enable; low = hold.
- ratio  input  NUM_CH*DIV_W  packed new ratios; channel i at bits [i*DIV_W +: DIV_W].
- load  input  NUM_CH  per-channel strobe; captures ratio field into pending register.
- sync_restart  input  1  forces all channels to start a new period on the next edge.
- clk_out  output  NUM_CH  divided waveform per channel, registered.
- tick  output  NUM_CH  one-cycle pulse in first cycle of each period, registered.
- ratio_ack  output  NUM_CH  one-cycle pulse when a pending ratio becomes active.

Behaviour:
- Reset (reset_n low, async):
  - clk_out=0, tick=0, ratio_ack=0.
  - Active ratio and pending ratio = DEFAULT_DIV; pending-valid flag cleared.
  - Phase state = "end of period", so the first enabled edge starts a period.
- Effective ratio: N = max(active ratio, 2). Values 0 and 1 are clamped to 2 at capture.
- High time: H = ceil(N/2); low time: N-H.
- Per channel, on each edge with enable[i]=1, count k advances 0,1,..,N-1,0,...
  - In the cycle where k is current: clk_out[i]=(k<H), tick[i]=(k==0).
  - Outputs are flop outputs computed from next-count, i.e. zero combinational path from the count.
- enable[i]=0:
  - Count and clk_out hold their values.
  - tick and ratio_ack are 0.
- Period boundary = an enabled edge on which k moves N-1 -> 0. At that edge:
  - If pending-valid, active ratio <= pending, pending-valid cleared, and ratio_ack pulses in the same cycle as tick.
  - The new period uses the new N.
- load[i]=1 at edge E:
  - Pending <= ratio field (clamped) and pending-valid set.
  - A later load before the boundary overwrites it: last wins, one ack.
  - A boundary at the same edge E still uses the prior state; the newly captured value applies at the next boundary.
- sync_restart=1 at edge E (overrides enable):
  - Every channel goes to k=0 with clk_out=1, tick=1.
  - Pending ratios are applied with ratio_ack, as at a normal boundary.
  - load at the same edge is captured for the following boundary.
- Reset mid-operation:
  - Immediate return to reset values.
  - Pending loads are discarded and no ack is issued.
- Channels are fully independent except for sync_restart.
- Counter never exceeds N-1; no wrap beyond the DIV_W range.

Test Plan:
- Ratio 4 on ch0, enable=1 after reset release -> clk_out 1,1,0,0 repeating; tick at k=0 every 4 cycles; first tick on first enabled edge.
- Ratio 5 -> clk_out high 3 cycles, low 2; tick period 5. Ratio 0 or 1 loaded -> behaves as 2 (toggle every cycle, tick every 2).
- Running at 4, load ratio 6 at k=1 -> current period completes 4 cycles; next period is 6 cycles with ratio_ack coincident with that tick. Loads of 7 then 3 before the boundary -> only 3 applied, single ack.
- enable deasserted for 3 cycles at k=2 -> clk_out and count frozen, no tick; resumes at k=3 on re-enable. Period stretched by exactly 3.
- ch0 ratio 4, ch1 ratio 6, out of phase; pulse sync_restart -> both tick and go high on the same cycle; common tick every 12 cycles thereafter.
- Assert reset_n low mid-period with a pending load -> outputs 0 immediately (asynchronously); after release, ratio = DEFAULT_DIV and no ratio_ack.
